// File: rtl/c_tile_writeback.sv
// Tile-major C writeback: buffers up to two MxN tiles and drains them row by row
// into an N-element-wide output memory port at row-major word addresses.
module c_tile_writeback #(
    parameter int OutDataWidth  = 32,
    parameter int M             = 4,
    parameter int N             = 4,
    parameter int SizeAddrWidth = 8,
    parameter int OutAddrWidth  = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           start_i,
    input  logic [SizeAddrWidth-1:0]       M_size_i,
    input  logic [SizeAddrWidth-1:0]       N_size_i,
    input  logic                           tile_valid_i,
    output logic                           tile_ready_o,
    input  logic [OutDataWidth*M*N-1:0]    tile_data_i,
    output logic                           out_we_o,
    output logic [OutAddrWidth-1:0]        out_addr_o,
    output logic [OutDataWidth*N-1:0]      out_wdata_o,
    output logic                           done_o
);

    localparam int RowWidth  = OutDataWidth * N;
    localparam int TileWidth = RowWidth * M;
    localparam int RowCntW   = (M > 1) ? $clog2(M) : 1;
    localparam int LogM      = $clog2(M);
    localparam int LogN      = $clog2(N);
    localparam int CntW      = 2 * SizeAddrWidth;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]               state_q,     state_d;
    logic [SizeAddrWidth-1:0] tn_max_q,    tn_max_d;
    logic [SizeAddrWidth-1:0] tm_max_q,    tm_max_d;
    logic [CntW-1:0]          total_q,     total_d;
    logic [CntW-1:0]          acc_q,       acc_d;
    logic [SizeAddrWidth-1:0] tn_q,        tn_d;
    logic [SizeAddrWidth-1:0] tm_q,        tm_d;
    logic [RowCntW-1:0]       row_q,       row_d;
    logic [1:0]               slot_valid_q, slot_valid_d;
    logic                     wr_ptr_q,    wr_ptr_d;
    logic                     rd_ptr_q,    rd_ptr_d;
    logic                     out_we_q,    out_we_d;
    logic [OutAddrWidth-1:0]  out_addr_q,  out_addr_d;
    logic [RowWidth-1:0]      out_wdata_q, out_wdata_d;
    logic                     done_q,      done_d;

    logic [SizeAddrWidth-1:0] tn_in;
    logic [SizeAddrWidth-1:0] tm_in;
    logic                     ready_w;
    logic                     load_en;
    logic [TileWidth-1:0]     slot_data [2];
    logic [TileWidth-1:0]     drain_tile;
    logic [RowWidth-1:0]      drain_rows [M];
    logic [OutAddrWidth-1:0]  addr_calc;
    logic                     last_row;
    logic                     last_tn;

    assign tn_in = N_size_i >> LogN;
    assign tm_in = M_size_i >> LogM;

    // Ready depends only on registered state, so a slot freed this cycle
    // becomes visible to the producer one cycle later.
    assign ready_w = (state_q == ST_RUN) && (slot_valid_q != 2'b11) && (acc_q < total_q);
    assign load_en = tile_valid_i && ready_w;

    // Two tile slots, written alternately; the write pointer always names a free slot.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            localparam logic SlotIdx = 1'(gi);
            logic [TileWidth-1:0] data_q;
            always_ff @(posedge clk_i) begin
                if (load_en && (wr_ptr_q == SlotIdx)) begin
                    data_q <= tile_data_i;
                end
            end
            assign slot_data[gi] = data_q;
        end
    endgenerate

    assign drain_tile = slot_data[rd_ptr_q];

    generate
        for (gi = 0; gi < M; gi++) begin : g_row
            assign drain_rows[gi] = drain_tile[gi*RowWidth +: RowWidth];
        end
    endgenerate

    // Address arithmetic is done modulo 2**OutAddrWidth throughout, which equals
    // truncating the full-width product.
    assign addr_calc = (OutAddrWidth'(tm_q) * OutAddrWidth'(M) + OutAddrWidth'(row_q))
                       * OutAddrWidth'(tn_max_q) + OutAddrWidth'(tn_q);

    assign last_row = (row_q == RowCntW'(M - 1));
    assign last_tn  = (tn_q == tn_max_q - SizeAddrWidth'(1));

    always_comb begin
        state_d      = state_q;
        tn_max_d     = tn_max_q;
        tm_max_d     = tm_max_q;
        total_d      = total_q;
        acc_d        = acc_q;
        tn_d         = tn_q;
        tm_d         = tm_q;
        row_d        = row_q;
        slot_valid_d = slot_valid_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        out_we_d     = 1'b0;
        out_addr_d   = out_addr_q;
        out_wdata_d  = out_wdata_q;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    tn_max_d     = tn_in;
                    tm_max_d     = tm_in;
                    total_d      = CntW'(tn_in) * CntW'(tm_in);
                    acc_d        = '0;
                    tn_d         = '0;
                    tm_d         = '0;
                    row_d        = '0;
                    slot_valid_d = 2'b00;
                    wr_ptr_d     = 1'b0;
                    rd_ptr_d     = 1'b0;
                    if ((tn_in == '0) || (tm_in == '0)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                if (load_en) begin
                    slot_valid_d[wr_ptr_q] = 1'b1;
                    wr_ptr_d               = ~wr_ptr_q;
                    acc_d                  = acc_q + CntW'(1);
                end

                if (slot_valid_q[rd_ptr_q]) begin
                    out_we_d    = 1'b1;
                    out_addr_d  = addr_calc;
                    out_wdata_d = drain_rows[row_q];
                    if (last_row) begin
                        // Tile finished: release its slot and step to the next tile position.
                        slot_valid_d[rd_ptr_q] = 1'b0;
                        rd_ptr_d               = ~rd_ptr_q;
                        row_d                  = '0;
                        if (last_tn) begin
                            tn_d = '0;
                            tm_d = tm_q + SizeAddrWidth'(1);
                        end else begin
                            tn_d = tn_q + SizeAddrWidth'(1);
                        end
                    end else begin
                        row_d = row_q + RowCntW'(1);
                    end
                end else if ((acc_q == total_q) && (slot_valid_q == 2'b00)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            tn_max_q     <= '0;
            tm_max_q     <= '0;
            total_q      <= '0;
            acc_q        <= '0;
            tn_q         <= '0;
            tm_q         <= '0;
            row_q        <= '0;
            slot_valid_q <= 2'b00;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            out_we_q     <= 1'b0;
            out_addr_q   <= '0;
            out_wdata_q  <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tn_max_q     <= tn_max_d;
            tm_max_q     <= tm_max_d;
            total_q      <= total_d;
            acc_q        <= acc_d;
            tn_q         <= tn_d;
            tm_q         <= tm_d;
            row_q        <= row_d;
            slot_valid_q <= slot_valid_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            out_we_q     <= out_we_d;
            out_addr_q   <= out_addr_d;
            out_wdata_q  <= out_wdata_d;
            done_q       <= done_d;
        end
    end

    assign tile_ready_o = ready_w;
    assign out_we_o     = out_we_q;
    assign out_addr_o   = out_addr_q;
    assign out_wdata_o  = out_wdata_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_c_tile_writeback.sv
// Bench for c_tile_writeback: table of size/rate cases with a row scoreboard and
// expected address lists, plus hand-written reset sequences.
module tb_c_tile_writeback;

    localparam int W      = 32;
    localparam int M      = 4;
    localparam int N      = 4;
    localparam int ROW_W  = W * N;
    localparam int TILE_W = ROW_W * M;
    localparam int NVEC   = 6;

    logic              clk;
    logic              rst_i;
    logic              start_i;
    logic [7:0]        m_size_i;
    logic [7:0]        n_size_i;
    logic              tile_valid_i;
    logic              tile_ready_o;
    logic [TILE_W-1:0] tile_data_i;
    logic              out_we_o;
    logic [7:0]        out_addr_o;
    logic [ROW_W-1:0]  out_wdata_o;
    logic              done_o;

    c_tile_writeback #(
        .OutDataWidth(W), .M(M), .N(N), .SizeAddrWidth(8), .OutAddrWidth(8)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .M_size_i     (m_size_i),
        .N_size_i     (n_size_i),
        .tile_valid_i (tile_valid_i),
        .tile_ready_o (tile_ready_o),
        .tile_data_i  (tile_data_i),
        .out_we_o     (out_we_o),
        .out_addr_o   (out_addr_o),
        .out_wdata_o  (out_wdata_o),
        .done_o       (done_o)
    );

    typedef struct {
        int m_size;
        int n_size;
        int gap;
        int n_tiles;
        int exp_writes;
        int exp_bursts;
        bit hold_ready;
    } vec_t;

    vec_t vecs [NVEC];
    int   addr_tab [NVEC][16];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [ROW_W-1:0] exp_q[$];
    int               addr_q[$];
    int  wr_count, burst_cnt, done_cnt, ready_seen, acc_cnt;
    int  last_wr_cyc, done_cyc, start_cyc;
    bit  prev_we = 1'b0;
    bit  hold_ready_chk = 1'b0;
    int  tile_seq = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(string name, logic [ROW_W-1:0] act, logic [ROW_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [TILE_W-1:0] make_tile(int seq);
        logic [TILE_W-1:0] t;
        for (int u = 0; u < M * N; u++) begin
            t[u*W +: W] = 32'(seq * 65536 + u);
        end
        return t;
    endfunction

    // Monitor: scoreboard pop on writes, push on accepted tiles, event bookkeeping.
    initial begin
        forever begin
            @(negedge clk);
            if (out_we_o === 1'b1) begin
                wr_count++;
                if (!prev_we) burst_cnt++;
                last_wr_cyc = cyc;
                $display("write cyc=%0d addr=%0d data=%h", cyc, out_addr_o, out_wdata_o);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr %0d written, no row pending", out_addr_o);
                end else begin
                    check("wdata", out_wdata_o, exp_q.pop_front());
                end
                if (addr_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL extra_addr: addr %0d written, no address expected", out_addr_o);
                end else begin
                    check("waddr", ROW_W'(out_addr_o), ROW_W'(addr_q.pop_front()));
                end
            end
            prev_we = (out_we_o === 1'b1);
            if (done_o === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (tile_ready_o === 1'b1) ready_seen++;
            if (start_i) start_cyc = cyc;
            if (hold_ready_chk && acc_cnt < 4) check("ready_hold", ROW_W'(tile_ready_o), 1);
            if (rst_i) begin
                exp_q.delete();
                addr_q.delete();
            end else if (tile_valid_i && tile_ready_o) begin
                acc_cnt++;
                for (int r = 0; r < M; r++) exp_q.push_back(tile_data_i[r*ROW_W +: ROW_W]);
            end
        end
    end

    task automatic clear_model();
        exp_q.delete();
        addr_q.delete();
        wr_count = 0; burst_cnt = 0; done_cnt = 0; ready_seen = 0; acc_cnt = 0;
        last_wr_cyc = -1; done_cyc = -1; start_cyc = -1;
    endtask

    task automatic do_start(int ms, int ns);
        m_size_i = 8'(ms);
        n_size_i = 8'(ns);
        @(posedge clk); #1;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic feed_tiles(int n_tiles, int gap);
        int  sent  = 0;
        int  idle  = 0;
        int  guard = 0;
        bit  fire;
        tile_valid_i = 1'b0;
        while (sent < n_tiles && guard < 2000) begin
            if (!tile_valid_i && idle == 0) begin
                tile_valid_i = 1'b1;
                tile_data_i  = make_tile(tile_seq);
            end
            @(negedge clk);
            fire = tile_valid_i && tile_ready_o;
            @(posedge clk); #1;
            guard++;
            if (fire) begin
                sent++;
                tile_seq++;
                tile_valid_i = 1'b0;
                idle = gap;
            end else if (idle > 0) begin
                idle--;
            end
        end
        tile_valid_i = 1'b0;
        if (sent < n_tiles) begin
            n_checks++;
            n_fail++;
            $display("FAIL feed_timeout: sent %0d tiles, required %0d", sent, n_tiles);
        end
    endtask

    task automatic run_test(int idx);
        vec_t v = vecs[idx];
        int   g = 0;
        clear_model();
        for (int i = 0; i < v.exp_writes; i++) addr_q.push_back(addr_tab[idx][i]);
        do_start(v.m_size, v.n_size);
        hold_ready_chk = v.hold_ready;
        if (v.n_tiles > 0) begin
            feed_tiles(v.n_tiles, v.gap);
        end else begin
            tile_valid_i = 1'b1;
            tile_data_i  = make_tile(tile_seq);
            repeat (3) begin @(posedge clk); #1; end
            tile_valid_i = 1'b0;
        end
        hold_ready_chk = 1'b0;
        while (done_cnt == 0 && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        repeat (3) begin @(posedge clk); #1; end
        check("write_count", ROW_W'(wr_count), ROW_W'(v.exp_writes));
        check("done_count", ROW_W'(done_cnt), 1);
        if (v.exp_writes > 0) check("done_after_last", ROW_W'(done_cyc), ROW_W'(last_wr_cyc + 1));
        else begin
            check("done_after_start", ROW_W'(done_cyc), ROW_W'(start_cyc + 1));
            check("ready_never", ROW_W'(ready_seen), 0);
        end
        check("bursts", ROW_W'(burst_cnt), ROW_W'(v.exp_bursts));
        check("rows_left", ROW_W'(exp_q.size()), 0);
        check("addrs_left", ROW_W'(addr_q.size()), 0);
        $display("case %0d M_size=%0d N_size=%0d gap=%0d writes=%0d bursts=%0d done_cyc=%0d",
                 idx, v.m_size, v.n_size, v.gap, wr_count, burst_cnt, done_cyc);
    endtask

    initial begin
        int g;
        vecs[0] = '{m_size: 4, n_size: 4, gap: 0, n_tiles: 1, exp_writes: 4,  exp_bursts: 1, hold_ready: 1'b0};
        vecs[1] = '{m_size: 8, n_size: 8, gap: 0, n_tiles: 4, exp_writes: 16, exp_bursts: 1, hold_ready: 1'b0};
        vecs[2] = '{m_size: 8, n_size: 8, gap: 9, n_tiles: 4, exp_writes: 16, exp_bursts: 4, hold_ready: 1'b1};
        vecs[3] = '{m_size: 8, n_size: 4, gap: 0, n_tiles: 2, exp_writes: 8,  exp_bursts: 1, hold_ready: 1'b0};
        vecs[4] = '{m_size: 4, n_size: 8, gap: 0, n_tiles: 2, exp_writes: 8,  exp_bursts: 1, hold_ready: 1'b0};
        vecs[5] = '{m_size: 8, n_size: 2, gap: 0, n_tiles: 0, exp_writes: 0,  exp_bursts: 0, hold_ready: 1'b0};
        addr_tab[0] = '{0, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        addr_tab[1] = '{0, 2, 4, 6, 1, 3, 5, 7, 8, 10, 12, 14, 9, 11, 13, 15};
        addr_tab[2] = '{0, 2, 4, 6, 1, 3, 5, 7, 8, 10, 12, 14, 9, 11, 13, 15};
        addr_tab[3] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 0, 0, 0, 0, 0, 0, 0};
        addr_tab[4] = '{0, 2, 4, 6, 1, 3, 5, 7, 0, 0, 0, 0, 0, 0, 0, 0};
        addr_tab[5] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

        // Reset held with a valid tile on the input: nothing may move.
        rst_i        = 1'b1;
        start_i      = 1'b0;
        m_size_i     = 8'd0;
        n_size_i     = 8'd0;
        tile_valid_i = 1'b1;
        tile_data_i  = make_tile(99);
        clear_model();
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_we", ROW_W'(out_we_o), 0);
            check("rst_ready", ROW_W'(tile_ready_o), 0);
            check("rst_done", ROW_W'(done_o), 0);
            check("rst_addr", ROW_W'(out_addr_o), 0);
            check("rst_wdata", out_wdata_o, 0);
        end
        @(posedge clk); #1;
        rst_i        = 1'b0;
        tile_valid_i = 1'b0;
        check("rst_no_writes", ROW_W'(wr_count), 0);

        for (int i = 0; i < NVEC; i++) run_test(i);

        // Reset after two row writes of a 4x4 run, then rerun from scratch.
        clear_model();
        for (int i = 0; i < 4; i++) addr_q.push_back(i);
        do_start(4, 4);
        feed_tiles(1, 0);
        g = 0;
        while (wr_count < 2 && g < 50) begin
            @(negedge clk); #1;
            g++;
        end
        rst_i = 1'b1;
        @(negedge clk);
        check("midrst_we", ROW_W'(out_we_o), 0);
        check("midrst_ready", ROW_W'(tile_ready_o), 0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        check("midrst_writes", ROW_W'(wr_count), 2);
        check("midrst_no_done", ROW_W'(done_cnt), 0);
        $display("mid-run reset applied after %0d writes", wr_count);
        run_test(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
